if_id_branch_unit: RTL

IF/ID pipeline register plus decode-stage branch resolution, sitting directly downstream of the Fetch stage. It captures the fetched instruction, PC, and branch prediction, then resolves conditional branches against the current flags. It returns the predictor update (wen_BTB, wen_BHT) and the redirect request (update_PC, actual_target) to Fetch. It also keeps saturating branch/misprediction counters for performance reporting.

---
 rtl/branch_pkg.sv | 24 ++
 rtl/branch_cond.sv | 32 +++
 rtl/if_id_branch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared decode definitions for branch handling: opcodes, condition codes
// and the bit positions of the {Z,V,N} flag bus.
package branch_pkg;

   localparam logic [3:0] OP_B   = 4'hC;
   localparam logic [3:0] OP_BR  = 4'hD;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      COND_NE     = 3'b000,
      COND_EQ     = 3'b001,
      COND_GT     = 3'b010,
      COND_LT     = 3'b011,
      COND_GTE    = 3'b100,
      COND_LTE    = 3'b101,
      COND_OVFL   = 3'b110,
      COND_ALWAYS = 3'b111
   } cond_t;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

endpackage

// File: rtl/branch_cond.sv
// Evaluates a branch condition code against the {Z,V,N} flags.
module branch_cond
   import branch_pkg::*;
(
   input  cond_t       cond,
   input  logic [2:0]  flags,
   output logic        cond_true
);

   logic z;
   logic v;
   logic n;

   always_comb begin
      z = flags[FLAG_Z];
      v = flags[FLAG_V];
      n = flags[FLAG_N];
      cond_true = 1'b0;
      case (cond)
         COND_NE:     cond_true = !z;
         COND_EQ:     cond_true = z;
         COND_GT:     cond_true = !z && !n;
         COND_LT:     cond_true = n;
         COND_GTE:    cond_true = z || (!z && !n);
         COND_LTE:    cond_true = n || z;
         COND_OVFL:   cond_true = v;
         COND_ALWAYS: cond_true = 1'b1;
         default:     cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/if_id_branch_unit.sv
// IF/ID pipeline register with decode-stage branch resolution, predictor
// update / redirect generation and saturating branch statistics.
module if_id_branch_unit
   import branch_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [15:0]       PC_curr,
   input  logic [15:0]       PC_next,
   input  logic [15:0]       PC_inst,
   input  logic [1:0]        prediction,
   input  logic [15:0]       predicted_target,
   input  logic [2:0]        flags,
   input  logic [15:0]       rs_data,
   output logic [15:0]       IF_ID_PC_curr,
   output logic [15:0]       IF_ID_PC_next,
   output logic [15:0]       IF_ID_inst,
   output logic [1:0]        IF_ID_prediction,
   output logic              IF_ID_valid,
   output logic              actual_taken,
   output logic [15:0]       actual_target,
   output logic              wen_BHT,
   output logic              wen_BTB,
   output logic              update_PC,
   output logic [CNT_W-1:0]  branch_count,
   output logic [CNT_W-1:0]  mispredict_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [15:0]      pc_curr_q, pc_curr_d;
   logic [15:0]      pc_next_q, pc_next_d;
   logic [15:0]      inst_q, inst_d;
   logic [1:0]       pred_q, pred_d;
   logic [15:0]      ptgt_q, ptgt_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] branch_count_q, branch_count_d;
   logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

   logic [3:0]  opcode;
   logic        is_br;
   logic        is_branch;
   logic        cond_true;
   logic        mispredicted;
   logic        target_miscomputed;
   logic [15:0] branch_offset;
   logic [15:0] target;

   branch_cond u_branch_cond (
      .cond      (cond_t'(inst_q[11:9])),
      .flags     (flags),
      .cond_true (cond_true)
   );

   // Resolution is purely combinational on the IF/ID contents; stall only
   // masks the side effects, not the computed direction/target.
   always_comb begin
      opcode             = inst_q[15:12];
      is_br              = (opcode == OP_BR);
      is_branch          = valid_q && ((opcode == OP_B) || is_br);
      branch_offset      = {{6{inst_q[8]}}, inst_q[8:0], 1'b0};
      target             = is_br ? rs_data : (pc_next_q + branch_offset);
      actual_taken       = is_branch && cond_true;
      actual_target      = actual_taken ? target : pc_next_q;
      mispredicted       = is_branch && (pred_q[1] != actual_taken);
      target_miscomputed = actual_taken && (ptgt_q != target);
      update_PC          = !stall && (mispredicted || target_miscomputed);
      wen_BHT            = !stall && is_branch;
      wen_BTB            = !stall && actual_taken && target_miscomputed;
   end

   // Register next state: reset beats flush, flush beats hold, hold beats load.
   always_comb begin
      pc_curr_d = pc_curr_q;
      pc_next_d = pc_next_q;
      inst_d    = inst_q;
      pred_d    = pred_q;
      ptgt_d    = ptgt_q;
      valid_d   = valid_q;
      if (!rst || update_PC) begin
         pc_curr_d = '0;
         pc_next_d = '0;
         inst_d    = '0;
         pred_d    = '0;
         ptgt_d    = '0;
         valid_d   = 1'b0;
      end else if (!stall) begin
         pc_curr_d = PC_curr;
         pc_next_d = PC_next;
         inst_d    = PC_inst;
         pred_d    = prediction;
         ptgt_d    = predicted_target;
         valid_d   = 1'b1;
      end
   end

   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (!rst) begin
         branch_count_d     = '0;
         mispredict_count_d = '0;
      end else if (!stall) begin
         if (is_branch && (branch_count_q != CNT_MAX)) begin
            branch_count_d = branch_count_q + CNT_ONE;
         end
         if (update_PC && (mispredict_count_q != CNT_MAX)) begin
            mispredict_count_d = mispredict_count_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      pc_curr_q          <= pc_curr_d;
      pc_next_q          <= pc_next_d;
      inst_q             <= inst_d;
      pred_q             <= pred_d;
      ptgt_q             <= ptgt_d;
      valid_q            <= valid_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
   end

   assign IF_ID_PC_curr    = pc_curr_q;
   assign IF_ID_PC_next    = pc_next_q;
   assign IF_ID_inst       = inst_q;
   assign IF_ID_prediction = pred_q;
   assign IF_ID_valid      = valid_q;
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule
